// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the PWM generator host interface:
//               command byte bit positions, default address width and the
//               instruction decoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int CMD_RW_BIT     = 7;
    localparam int CMD_HL_BIT     = 6;
    localparam int ADDR_W_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DATA  = 3'd1,
        ST_RD_REQ     = 3'd2,
        ST_RD_CAP     = 3'd3,
        ST_WAIT_DUMMY = 3'd4
    } decode_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser for a single asynchronous bit,
//               with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; reset both stages to the configured idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Turns the two-byte SPI command stream from spi_bridge into
//               single-cycle register-file read/write strobes and returns
//               read data to the bridge through data_out.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import pwm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              hi_sel,
    output logic [7:0]        data_write,
    input  logic [7:0]        data_read
);

    decode_state_t state;
    decode_state_t state_next;
    logic          cs_s;
    logic          load_cmd;
    logic          load_wdata;
    logic          cap_rdata;
    logic          write_next;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (cs_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, load enables and strobes; an inactive chip select aborts
    // any partial transaction and blocks every byte-driven action.
    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        load_wdata = 1'b0;
        cap_rdata  = 1'b0;
        write_next = 1'b0;
        read       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (byte_sync) begin
                    load_cmd   = 1'b1;
                    state_next = data_in[CMD_RW_BIT] ? ST_WAIT_DATA : ST_RD_REQ;
                end
            end
            ST_WAIT_DATA: begin
                if (byte_sync) begin
                    load_wdata = 1'b1;
                    write_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                read       = 1'b1;
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                cap_rdata  = 1'b1;
                state_next = ST_WAIT_DUMMY;
            end
            ST_WAIT_DUMMY: begin
                if (byte_sync) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (cs_s) begin
            state_next = ST_IDLE;
            load_cmd   = 1'b0;
            load_wdata = 1'b0;
            write_next = 1'b0;
        end
    end

    // Command fields, write data, read-back byte and the registered write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            hi_sel     <= 1'b0;
            data_write <= 8'h00;
            data_out   <= 8'h00;
            write      <= 1'b0;
        end else begin
            write <= write_next;
            if (load_cmd) begin
                addr   <= data_in[ADDR_W-1:0];
                hi_sel <= data_in[CMD_HL_BIT];
            end
            if (load_wdata) begin
                data_write <= data_in;
            end
            if (cap_rdata) begin
                data_out <= data_read;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode
// Description : Self-checking bench for instr_decode: directed transactions
//               followed by random frames, checked against a register-file
//               model and the command byte rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_read = 8'h00;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic       hi_sel;
    logic [7:0] data_write;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    // Register file contents indexed by {hi_sel, addr}; expected decoder state.
    logic [7:0] mem [128];
    logic [7:0] exp_dout;
    logic [7:0] last_wdata;

    instr_decode #(.ADDR_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .hi_sel     (hi_sel),
        .data_write (data_write),
        .data_read  (data_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: data is valid exactly one cycle after read, garbage otherwise.
    always @(posedge clk) begin
        data_read <= read ? mem[{hi_sel, addr}] : 8'($urandom);
    end

    // Strobe monitor: pulse counting, width and overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (read || write || prev_rd || prev_wr) begin
                chk("strobe_overlap", {31'b0, read & write}, 0);
                if (prev_rd) chk("read_width", {31'b0, read}, 0);
                if (prev_wr) chk("write_width", {31'b0, write}, 0);
            end
            if (read)  rd_cnt <= rd_cnt + 1;
            if (write) wr_cnt <= wr_cnt + 1;
        end
        prev_rd <= read;
        prev_wr <= write;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte for one cycle (T); returns at T+1, just after the edge.
    task automatic pulse_byte(input logic [7:0] b);
        @(negedge clk);
        data_in   = b;
        byte_sync = 1'b1;
        @(posedge clk);
        #1;
        byte_sync = 1'b0;
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        cs_n = 1'b1;
        tick(4);
    endtask

    // One full two-byte transaction with timing checks against the model.
    task automatic xfer(input logic [7:0] cmd, input logic [7:0] dat);
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        pulse_byte(cmd);
        chk("cmd_addr", {26'b0, addr}, {26'b0, cmd[5:0]});
        chk("cmd_hi_sel", {31'b0, hi_sel}, {31'b0, cmd[6]});
        if (cmd[7]) begin
            chk("wr_cmd_no_write", {31'b0, write}, 0);
            tick(14);
            pulse_byte(dat);
            chk("write_pulse", {31'b0, write}, 1);
            chk("write_data", {24'b0, data_write}, {24'b0, dat});
            chk("write_addr", {25'b0, hi_sel, addr}, {25'b0, cmd[6:0]});
            chk("wr_dout_held", {24'b0, data_out}, {24'b0, exp_dout});
            mem[cmd[6:0]] = dat;
            last_wdata = dat;
            tick(1);
            chk("write_end", {31'b0, write}, 0);
        end else begin
            chk("read_pulse", {31'b0, read}, 1);
            tick(1);
            chk("read_end", {31'b0, read}, 0);
            tick(1);
            exp_dout = mem[cmd[6:0]];
            chk("read_dout", {24'b0, data_out}, {24'b0, exp_dout});
            chk("rd_wdata_held", {24'b0, data_write}, {24'b0, last_wdata});
            tick(12);
            chk("dummy_dout", {24'b0, data_out}, {24'b0, exp_dout});
            pulse_byte(dat);
            chk("dummy_no_strobe", {30'b0, read, write}, 0);
        end
        tick(14);
        chk("read_count", rd_cnt - r0, {31'b0, ~cmd[7]});
        chk("write_count", wr_cnt - w0, {31'b0, cmd[7]});
    endtask

    initial begin
        int w0;
        int nx;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        exp_dout   = 8'h00;
        last_wdata = 8'h00;

        // Reset values.
        tick(3);
        chk("rst_outputs", {data_out, data_write, 6'b0, addr, 6'b0, read, write},
            {8'h00, 8'h00, 16'h0000});
        chk("rst_hi_sel", {31'b0, hi_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Single write.
        frame_begin();
        xfer(8'h85, 8'h3C);
        frame_end();

        // Single read of a known value.
        mem[7'h45] = 8'hA7;
        frame_begin();
        xfer(8'h45, 8'h00);
        frame_end();

        // Back-to-back transactions in one frame.
        frame_begin();
        xfer(8'h81, 8'h11);
        xfer(8'h02, 8'h00);
        frame_end();

        // CS abort between command and data; a byte while deselected is ignored.
        w0 = wr_cnt;
        frame_begin();
        pulse_byte(8'h83);
        tick(3);
        cs_n = 1'b1;
        tick(6);
        pulse_byte(8'hAA);
        tick(4);
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_wdata", {24'b0, data_write}, {24'b0, last_wdata});
        frame_begin();
        xfer(8'h02, 8'h00);
        frame_end();

        // Reset in the middle of a write transaction.
        frame_begin();
        pulse_byte(8'h84);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {data_out, data_write, 6'b0, addr, 6'b0, read, write},
            {8'h00, 8'h00, 16'h0000});
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("midrst_hold", {data_out, data_write, 5'b0, hi_sel, addr, 6'b0, read, write},
                {8'h00, 8'h00, 16'h0000});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_dout   = 8'h00;
        last_wdata = 8'h00;
        tick(4);
        w0 = wr_cnt;
        xfer(8'h55, 8'h00);
        chk("midrst_no_write", wr_cnt - w0, 0);
        frame_end();

        // Random frames of one to three transactions.
        for (int f = 0; f < 24; f++) begin
            frame_begin();
            nx = $urandom_range(1, 3);
            for (int k = 0; k < nx; k++) begin
                xfer(8'($urandom), 8'($urandom));
            end
            frame_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_decode.md
# instr_decode

Command-level decoder that sits directly downstream of `spi_bridge` in the PWM generator. It turns the byte stream (`byte_sync`/`data_in`) into single-cycle register-file `read`/`write` strobes. It loads read data into `data_out`, so the bridge shifts that data out on the host's next byte. Every SPI transaction is two bytes: a command byte, then a data byte (write) or a dummy byte (read).

## Interface
Parameters:
- `ADDR_W`, default 6: register address width, taken from command bits [5:0].

Ports:
- `clk` input 1: system clock, same clock as `spi_bridge`.
- `rst_n` input 1: asynchronous, active-low reset.
- `cs_n` input 1: raw SPI chip select, asynchronous; synchronised internally.
- `byte_sync` input 1: one-cycle pulse from `spi_bridge`; `data_in` is valid in that cycle.
- `data_in` input 8: byte received from the host.
- `data_out` output 8: byte the bridge returns on the next SPI byte; registered.
- `read` output 1: one-cycle read strobe to the register file.
- `write` output 1: one-cycle write strobe to the register file.
- `addr` output ADDR_W: register address; held from command capture until the next command.
- `hi_sel` output 1: high/low byte select for 16-bit registers; held like `addr`.
- `data_write` output 8: write data; valid in the `write` cycle, held afterwards.
- `data_read` input 8: register-file read data; valid exactly one cycle after `read`.

## Operation
- Command byte layout:
  - bit7 = 1 means write, 0 means read.
  - bit6 = `hi_sel`.
  - bits[5:0] = `addr`.
- FSM states: IDLE, WAIT_DATA, RD_REQ, RD_CAP, WAIT_DUMMY.
- IDLE:
  - On `byte_sync`, latch `addr`/`hi_sel` from `data_in`.
  - bit7 = 1: go to WAIT_DATA.
  - bit7 = 0: go to RD_REQ.
- RD_REQ:
  - Assert `read` for one cycle, then go to RD_CAP.
- RD_CAP:
  - `data_out` <= `data_read`, then go to WAIT_DUMMY.
- WAIT_DUMMY:
  - On `byte_sync`, discard `data_in`, go to IDLE. No strobe.
- WAIT_DATA:
  - On `byte_sync`, `data_write` <= `data_in`.
  - Assert `write` for one cycle, then go to IDLE.
- `data_out` changes only in RD_CAP. Write transactions leave it unchanged.
- Multiple transactions per CS frame are legal. After each 2-byte transaction the next byte is a new command.
- CS abort: `cs_n` goes through a 2-FF sync to give `cs_s`.
  - While `cs_s` = 1, the state is forced to IDLE.
  - `byte_sync` is ignored while `cs_s` = 1.
  - No `write` is issued for an incomplete write transaction.
- `byte_sync` arriving in RD_REQ or RD_CAP is ignored. The bus guarantees at least 16 clk per byte, so this cannot occur legally.
- Reset values:
  - `data_out`, `addr`, `hi_sel`, and `data_write` are 0.
  - `read` and `write` are 0.
  - State is IDLE.
  - Sync flops are 1 (CS inactive).
- Reset asserted mid-transaction: return to IDLE immediately. The partial transaction is lost and no strobe is issued.

## Timing
- Let T be the cycle in which `byte_sync` is high.
- Write path:
  - Command byte at T: `addr`/`hi_sel` are valid from T+1.
  - Data byte at T: `write` is high in cycle T+1 only; `data_write` is valid at T+1.
- Read path:
  - Command byte at T: `read` is high in cycle T+1.
  - `data_read` is sampled at T+2.
  - `data_out` is valid from T+3, well before the host's next first SCLK edge.
- CS:
  - `cs_s` lags `cs_n` by 2 clk.
  - The host keeps `cs_n` low for at least 4 clk after the last SCLK edge, so the final `byte_sync` is accepted.
- Strobes never overlap: `read` and `write` are never high in the same cycle.

## Structure
- Shared package `pwm_pkg` holds:
  - command bit positions `CMD_RW_BIT` = 7 and `CMD_HL_BIT` = 6;
  - the `ADDR_W` default;
  - the state encoding enum.
- One sub-module, `sync_2ff`: a generic 2-flop synchroniser with a reset value parameter, used for `cs_n` with reset value 1.
- The FSM, latches and strobe generation live in `instr_decode`.

## Test plan
- Write: frame with cmd 0x85, data 0x3C.
  - Exactly one `write` pulse, with `addr` = 5, `hi_sel` = 0, `data_write` = 0x3C, at T+1 of the second `byte_sync`.
  - No `read` pulse.
- Read: cmd 0x45, register model returns 0xA7 one cycle after `read`.
  - One `read` pulse with `addr` = 5, `hi_sel` = 1.
  - `data_out` = 0xA7 by T+3.
  - Bytes shifted back by the bridge during the dummy byte are 0xA7.
- Back-to-back in one frame: 0x81/0x11, then 0x02/dummy.
  - `write` to addr 1 with 0x11.
  - Then `read` of addr 2.
  - State returns to IDLE between the two transactions.
- CS abort: cmd 0x83, then `cs_n` high before the data byte; new frame with 0x02/dummy.
  - No `write` occurs.
  - The new frame decodes 0x02 as a read command.
- Reset mid-transaction: cmd 0x84, assert `rst_n` low for 3 clk, then send byte 0x55.
  - All outputs read 0 during reset.
  - 0x55 is treated as a read command for addr 0x15, not as write data.
- Strobe width: over all of the above, `read`/`write` are never high for 2 consecutive cycles and never high simultaneously.
